// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet datapath: default sample width,
// feature-map dimensions of each layer, and the window feeder state set.
package lenet_pkg;

  localparam int bitwidth_default = 17;

  localparam int conv1_map_width  = 28;
  localparam int conv1_map_height = 28;
  localparam int conv2_map_width  = 10;
  localparam int conv2_map_height = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EMIT0 = 3'd1,
    EMIT1 = 3'd2,
    EMIT2 = 3'd3,
    EMIT3 = 3'd4,
    GAP   = 3'd5
  } feeder_state_t;

endpackage

// File: rtl/pool_window_feeder_if.sv
// Pixel-in / window-out signal bundle between a conv layer, the window
// feeder and pool_buffer. The feeder is the slave; its environment the master.
interface pool_window_feeder_if
  import lenet_pkg::*;
#(
  parameter int bitwidth = bitwidth_default
);

  logic                       in_valid;
  logic signed [bitwidth-1:0] data_in;
  logic                       in_ready;
  logic signed [bitwidth-1:0] data_out;
  logic                       flag_start;
  logic                       flag_frame_done;

  modport master (
    output in_valid, data_in,
    input  in_ready, data_out, flag_start, flag_frame_done
  );

  modport slave (
    input  in_valid, data_in,
    output in_ready, data_out, flag_start, flag_frame_done
  );

endinterface

// File: rtl/pool_window_feeder_line_buffer.sv
// One-row sample store holding the even row of the current row pair.
// Synchronous write, combinational read; contents are never reset because
// every entry is rewritten in the even row before the odd row reads it.
module line_buffer
  import lenet_pkg::*;
#(
  parameter int bitwidth  = bitwidth_default,
  parameter int map_width = conv1_map_width,
  parameter int addr_w    = (map_width > 1) ? $clog2(map_width) : 1
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [addr_w-1:0]          wr_addr,
  input  logic signed [bitwidth-1:0] wr_data,
  input  logic [addr_w-1:0]          rd_addr,
  output logic signed [bitwidth-1:0] rd_data
);

  logic signed [bitwidth-1:0] mem [map_width];

  // Store the incoming even-row pixel at its column.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pool_window_feeder.sv
// Re-serialises a raster-order feature map into 2x2 windows (top-left,
// top-right, bottom-left, bottom-right) for pool_buffer, followed by one
// idle cycle per window in which pool_buffer performs its transfer.
module pool_window_feeder
  import lenet_pkg::*;
#(
  parameter int bitwidth   = bitwidth_default,
  parameter int map_width  = conv1_map_width,
  parameter int map_height = conv1_map_height
) (
  input  logic               clk,
  input  logic               reset,
  pool_window_feeder_if.slave bus
);

  localparam int col_w = (map_width  > 1) ? $clog2(map_width)  : 1;
  localparam int row_w = (map_height > 1) ? $clog2(map_height) : 1;
  localparam logic [col_w-1:0] last_col = col_w'(map_width - 1);
  localparam logic [row_w-1:0] last_row = row_w'(map_height - 1);

  generate
    if ((map_width % 2) != 0 || (map_height % 2) != 0 || map_width < 2 || map_height < 2) begin : g_bad_dims
      $error("pool_window_feeder: map_width and map_height must be even and at least 2");
    end
  endgenerate

  feeder_state_t state, next_state;

  logic [col_w-1:0] col;
  logic [row_w-1:0] row;
  logic [col_w-1:0] win_col;
  logic             last_window;
  logic signed [bitwidth-1:0] bl, br;
  logic signed [bitwidth-1:0] lb_rd_data;
  logic [col_w-1:0] lb_rd_addr;
  logic             accept;
  logic             window_hit;

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign window_hit   = accept && row[0] && col[0];

  // While idle the triggering pixel's column is still live in col, so the
  // top-left fetch uses col-1; during the burst the latched column is used.
  assign lb_rd_addr = (state == IDLE) ? (col - col_w'(1)) : win_col;

  line_buffer #(
    .bitwidth (bitwidth),
    .map_width(map_width),
    .addr_w   (col_w)
  ) u_line_buffer (
    .clk    (clk),
    .wr_en  (accept && !row[0]),
    .wr_addr(col),
    .wr_data(bus.data_in),
    .rd_addr(lb_rd_addr),
    .rd_data(lb_rd_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Burst sequencing: a bottom-right pixel starts a fixed five-cycle burst.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (window_hit) next_state = EMIT0;
      EMIT0:   next_state = EMIT1;
      EMIT1:   next_state = EMIT2;
      EMIT2:   next_state = EMIT3;
      EMIT3:   next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == last_col) begin
        col <= '0;
        row <= (row == last_row) ? '0 : row + row_w'(1);
      end else begin
        col <= col + col_w'(1);
      end
    end
  end

  // Capture the window column and whether this window closes the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_col     <= '0;
      last_window <= 1'b0;
    end else if (window_hit) begin
      win_col     <= col;
      last_window <= (row == last_row) && (col == last_col);
    end
  end

  // Bottom-row samples of the window in progress; always written before use.
  always_ff @(posedge clk) begin
    if (accept && row[0] && !col[0]) bl <= bus.data_in;
    if (window_hit)                  br <= bus.data_in;
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.data_out        <= '0;
      bus.flag_start      <= 1'b0;
      bus.flag_frame_done <= 1'b0;
    end else begin
      bus.flag_start      <= (next_state == EMIT0) || (next_state == EMIT1) ||
                             (next_state == EMIT2) || (next_state == EMIT3);
      bus.flag_frame_done <= (next_state == GAP) && last_window;
      unique case (next_state)
        EMIT0, EMIT1: bus.data_out <= lb_rd_data;
        EMIT2:        bus.data_out <= bl;
        EMIT3:        bus.data_out <= br;
        default:      bus.data_out <= bus.data_out;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder on a 4x4 map. A pool_buffer-style collector
// groups flag_start samples into windows; expected windows are cut straight
// out of the driven frame array.
module tb_pool_window_feeder;
  import lenet_pkg::*;

  localparam int bw   = 17;
  localparam int mw   = 4;
  localparam int mh   = 4;
  localparam int nwin = (mw / 2) * (mh / 2);
  localparam int npix = mw * mh;

  typedef logic signed [bw-1:0] pix_t;
  typedef struct packed { pix_t a; pix_t b; pix_t c; pix_t d; } win_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pool_window_feeder_if #(.bitwidth(bw)) bus ();

  pool_window_feeder #(
    .bitwidth  (bw),
    .map_width (mw),
    .map_height(mh)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vectors     = 0;
  int   n_miscompares = 0;
  pix_t frame [mh][mw];
  int   acc_edge [2*npix];
  win_t got [$];
  win_t exp_q [$];
  pix_t partial [$];
  int   fd_count   = 0;
  int   fd_cyc     = -1;
  int   last_d_cyc = -1;
  int   wins_at_fd = -1;
  logic obs_ready [4096];
  logic obs_start [4096];

  // pool_buffer model: latches a,b,c,d from consecutive flag_start cycles.
  always @(negedge clk) begin
    if (cyc < 4096) begin
      obs_ready[cyc] = bus.in_ready;
      obs_start[cyc] = bus.flag_start;
    end
    if (reset) begin
      partial.delete();
    end else begin
      if (bus.flag_start) begin
        partial.push_back(bus.data_out);
        if (partial.size() == 4) begin
          got.push_back('{partial[0], partial[1], partial[2], partial[3]});
          partial.delete();
          last_d_cyc = cyc;
        end
      end
      if (bus.flag_frame_done) begin
        fd_count++;
        fd_cyc     = cyc;
        wins_at_fd = got.size();
      end
    end
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic fill_ramp();
    for (int r = 0; r < mh; r++)
      for (int c = 0; c < mw; c++)
        frame[r][c] = pix_t'(4 * r + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < mh; r++)
      for (int c = 0; c < mw; c++)
        frame[r][c] = pix_t'($urandom);
  endtask

  task automatic build_expected();
    for (int wr = 0; wr < mh / 2; wr++)
      for (int wc = 0; wc < mw / 2; wc++)
        exp_q.push_back('{frame[2*wr][2*wc],   frame[2*wr][2*wc+1],
                          frame[2*wr+1][2*wc], frame[2*wr+1][2*wc+1]});
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_pixel(input pix_t v, input int bubble_pct, output int edge_no);
    int guard;
    guard = 0;
    while (bubble_pct > 0 && $urandom_range(99) < bubble_pct && guard < 20) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.data_in  = v;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_vectors++;
      n_miscompares++;
      $display("[TB] FAIL in_ready_timeout: in_ready=%0b required=1", bus.in_ready);
    end
    @(posedge clk);
    edge_no = cyc + 1;
    @(negedge clk);
  endtask

  task automatic send_frame(input int bubble_pct, input int base, input int count);
    for (int i = 0; i < count; i++)
      send_pixel(frame[i / mw][i % mw], bubble_pct, acc_edge[base + i]);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (10) @(negedge clk);
  endtask

  task automatic start_capture();
    got.delete();
    exp_q.delete();
    fd_count   = 0;
    fd_cyc     = -1;
    wins_at_fd = -1;
  endtask

  task automatic compare_windows(input string tag);
    n_vectors++;
    if (got.size() !== exp_q.size()) begin
      n_miscompares++;
      $display("[TB] FAIL %s_count: got %0d windows, required %0d", tag, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_vectors++;
      if (got[i] !== exp_q[i]) begin
        n_miscompares++;
        $display("[TB] FAIL %s_win%0d: got %h required %h", tag, i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    repeat (3) @(negedge clk);
    n_vectors += 4;
    if (bus.in_ready !== 1'b1) begin
      n_miscompares++; $display("[TB] FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
    if (bus.flag_start !== 1'b0) begin
      n_miscompares++; $display("[TB] FAIL reset_flag_start: got %b required 0", bus.flag_start);
    end
    if (bus.data_out !== '0) begin
      n_miscompares++; $display("[TB] FAIL reset_data_out: got %h required 0", bus.data_out);
    end
    if (bus.flag_frame_done !== 1'b0) begin
      n_miscompares++; $display("[TB] FAIL reset_frame_done: got %b required 0", bus.flag_frame_done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_continuous();
    start_capture();
    fill_ramp();
    build_expected();
    send_frame(0, 0, npix);
    drain();
    compare_windows("continuous");
    n_vectors += 3;
    if (fd_count !== 1) begin
      n_miscompares++; $display("[TB] FAIL frame_done_count: got %0d required 1", fd_count);
    end
    if (wins_at_fd !== nwin) begin
      n_miscompares++; $display("[TB] FAIL frame_done_position: got after %0d windows required %0d", wins_at_fd, nwin);
    end
    if (fd_cyc !== last_d_cyc + 1) begin
      n_miscompares++; $display("[TB] FAIL frame_done_gap: got cycle %0d required %0d", fd_cyc, last_d_cyc + 1);
    end
  endtask

  task automatic test_window_timing();
    int k;
    start_capture();
    fill_ramp();
    send_frame(0, 0, npix);
    drain();
    k = acc_edge[5];
    n_vectors++;
    if (acc_edge[6] !== k + 6) begin
      n_miscompares++; $display("[TB] FAIL accept_after_gap: got edge %0d required %0d", acc_edge[6], k + 6);
    end
    if (k + 5 < 4096) begin
      for (int j = 0; j < 6; j++) begin
        n_vectors += 2;
        if (obs_ready[k + j] !== (j == 5)) begin
          n_miscompares++;
          $display("[TB] FAIL in_ready_k%0d: got %b required %b", j + 1, obs_ready[k + j], (j == 5));
        end
        if (obs_start[k + j] !== (j < 4)) begin
          n_miscompares++;
          $display("[TB] FAIL flag_start_k%0d: got %b required %b", j + 1, obs_start[k + j], (j < 4));
        end
      end
    end else begin
      n_vectors++;
      n_miscompares++;
      $display("[TB] FAIL timing_window: got edge %0d required below 4091", k);
    end
  endtask

  task automatic test_reset_mid_burst();
    fill_ramp();
    send_frame(0, 0, 14);
    @(posedge clk);
    #1;
    n_vectors++;
    if (bus.flag_start !== 1'b1 || bus.data_out !== pix_t'(9)) begin
      n_miscompares++;
      $display("[TB] FAIL pre_reset_emit1: got start=%b data=%0d required start=1 data=9", bus.flag_start, bus.data_out);
    end
    reset = 1'b1;
    #1;
    n_vectors += 3;
    if (bus.flag_start !== 1'b0) begin
      n_miscompares++; $display("[TB] FAIL midreset_flag_start: got %b required 0", bus.flag_start);
    end
    if (bus.data_out !== '0) begin
      n_miscompares++; $display("[TB] FAIL midreset_data_out: got %h required 0", bus.data_out);
    end
    if (bus.in_ready !== 1'b1) begin
      n_miscompares++; $display("[TB] FAIL midreset_in_ready: got %b required 1", bus.in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_capture();
    build_expected();
    send_frame(0, 0, npix);
    drain();
    compare_windows("after_reset");
  endtask

  task automatic test_random_bubbles();
    start_capture();
    fill_ramp();
    build_expected();
    send_frame(50, 0, npix);
    drain();
    compare_windows("bubbles_ramp");
    start_capture();
    fill_random();
    build_expected();
    send_frame(50, 0, npix);
    drain();
    compare_windows("bubbles_random");
  endtask

  task automatic test_sign_extremes();
    start_capture();
    fill_random();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        frame[r][c]         = pix_t'(-65536);
        frame[r + 2][c + 2] = pix_t'(65535);
      end
    build_expected();
    send_frame(0, 0, npix);
    drain();
    compare_windows("sign_extremes");
  endtask

  task automatic test_back_to_back();
    start_capture();
    fill_ramp();
    build_expected();
    build_expected();
    send_frame(0, 0, npix);
    bus.in_valid = 1'b1;
    send_frame(0, npix, npix);
    drain();
    compare_windows("back_to_back");
    n_vectors++;
    if (fd_count !== 2) begin
      n_miscompares++; $display("[TB] FAIL b2b_frame_done_count: got %0d required 2", fd_count);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    test_reset();
    test_frame_continuous();
    test_window_timing();
    test_reset_mid_burst();
    test_random_bubbles();
    test_sign_extremes();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
